// File: rtl/decode_stage_pipe.sv
`default_nettype none
// =============================================================================
// Module   : decode_stage_pipe
// Brief    : Registered decode stage: 16-entry register bank, EX/MEM/WB operand
//            forwarding, load-use bubble insertion, branch target and flush.
//            Optional macro DECODE_IMM_SIGN_EXT_EN sign-extends imm19/imm28.
// Revision : 1.0 - initial release
// =============================================================================
module decode_stage_pipe #(
    parameter int BUS      = 32,
    parameter int PC_REG   = 14,
    parameter int ZERO_REG = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_instr,
    input  logic [BUS-1:0] in_pc,
    input  logic           wb_we,
    input  logic [3:0]     wb_rd,
    input  logic [BUS-1:0] wb_data,
    input  logic           ex_fw_valid,
    input  logic [3:0]     ex_fw_rd,
    input  logic [BUS-1:0] ex_fw_data,
    input  logic           mem_fw_valid,
    input  logic [3:0]     mem_fw_rd,
    input  logic [BUS-1:0] mem_fw_data,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     out_funtype,
    output logic [1:0]     out_funcode,
    output logic [3:0]     out_rd,
    output logic [3:0]     out_ropa,
    output logic [3:0]     out_ropb,
    output logic           out_ropa_is_reg,
    output logic           out_ropb_is_reg,
    output logic [BUS-1:0] out_opa,
    output logic [BUS-1:0] out_opb,
    output logic [BUS-1:0] out_str_data,
    output logic [BUS-1:0] out_pc,
    output logic [BUS-1:0] out_br_target,
    output logic           out_wb,
    output logic           out_memrd,
    output logic           out_memwr,
    output logic           out_cachewr,
    output logic           out_branch
);

    localparam logic [3:0] c_pc_reg   = 4'(PC_REG);
    localparam logic [3:0] c_zero_reg = 4'(ZERO_REG);

    logic [BUS-1:0] r_bank [16];
    logic           r_ld_pend;
    logic [3:0]     r_ld_rd;

    logic [1:0]     w_funtype, w_funcode;
    logic [3:0]     w_rd, w_rs, w_rx;
    logic           w_selimm;
    logic           w_cls_reg, w_cls_mem, w_cls_br, w_cls_krn;
    logic           w_is_cmp, w_is_mov, w_is_ld, w_is_st, w_is_cwr, w_wb;
    logic [BUS-1:0] w_imm19, w_imm28, w_imm4, w_imm;
    logic           w_zero_a, w_use_imm;
    logic [3:0]     w_src_a, w_ropa, w_ropb;
    logic [BUS-1:0] w_val_a, w_val_b, w_val_d, w_opa, w_opb;
    logic           w_hazard, w_advance, w_accept;

    assign w_funtype = in_instr[31:30];
    assign w_funcode = in_instr[29:28];
    assign w_rd      = in_instr[27:24];
    assign w_rs      = in_instr[23:20];
    assign w_rx      = in_instr[19:16];
    assign w_selimm  = in_instr[0];

    assign w_cls_reg = (w_funtype == 2'b00);
    assign w_cls_mem = (w_funtype == 2'b01);
    assign w_cls_br  = (w_funtype == 2'b10);
    assign w_cls_krn = (w_funtype == 2'b11);
    assign w_is_cmp  = w_cls_reg && (w_funcode == 2'b11);
    assign w_is_mov  = w_cls_reg && (w_funcode == 2'b10);
    assign w_is_ld   = w_cls_mem && (w_funcode == 2'b00);
    assign w_is_st   = w_cls_mem && (w_funcode == 2'b01);
    assign w_is_cwr  = w_cls_krn && (w_funcode == 2'b10);
    assign w_wb      = (w_cls_reg && !w_is_cmp) || w_is_ld || w_cls_br
                     || (w_cls_krn && (w_funcode == 2'b00));

`ifdef DECODE_IMM_SIGN_EXT_EN
    assign w_imm19 = {{(BUS-19){in_instr[19]}}, in_instr[19:1]};
    assign w_imm28 = {{(BUS-28){in_instr[27]}}, in_instr[27:0]};
`else
    assign w_imm19 = {{(BUS-19){1'b0}}, in_instr[19:1]};
    assign w_imm28 = {{(BUS-28){1'b0}}, in_instr[27:0]};
`endif
    assign w_imm4  = {{(BUS-4){1'b0}}, in_instr[23:20]};
    assign w_imm   = w_is_cwr ? w_imm4 : (w_cls_reg ? w_imm19 : w_imm28);

    // CMP and branches compare/use rd as the A operand
    assign w_src_a   = ((w_cls_reg && !w_is_cmp) || w_cls_mem) ? w_rs : w_rd;
    assign w_zero_a  = w_is_mov || w_cls_krn;
    assign w_use_imm = w_selimm || w_is_cwr;

    function automatic logic [BUS-1:0] read_reg(input logic [3:0] r);
        logic [BUS-1:0] v;
        if (r == c_zero_reg)                         v = '0;
        else if (r == c_pc_reg)                      v = in_pc;
        else if (ex_fw_valid && (ex_fw_rd == r))     v = ex_fw_data;
        else if (mem_fw_valid && (mem_fw_rd == r))   v = mem_fw_data;
        else if (wb_we && (wb_rd == r))              v = wb_data;
        else                                         v = r_bank[r];
        return v;
    endfunction

    always_comb begin
        w_val_a = read_reg(w_src_a);
        w_val_b = read_reg(w_rx);
        w_val_d = read_reg(w_rd);
    end

    assign w_opa  = w_zero_a  ? '0         : w_val_a;
    assign w_ropa = w_zero_a  ? c_zero_reg : w_src_a;
    assign w_opb  = w_use_imm ? w_imm      : w_val_b;
    assign w_ropb = w_use_imm ? c_zero_reg : w_rx;

    assign w_hazard = r_ld_pend && in_valid &&
                      ((!w_zero_a  && (w_src_a == r_ld_rd)) ||
                       (!w_use_imm && (w_rx    == r_ld_rd)) ||
                       (w_is_st    && (w_rd    == r_ld_rd)));

    assign w_advance = !out_valid || out_ready;
    // Flush drains whatever fetch offers so the front end never stalls on it
    assign in_ready  = rst_n && (flush || (w_advance && !w_hazard));
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_bank[i] <= '0;
            r_ld_pend       <= 1'b0;
            r_ld_rd         <= '0;
            out_valid       <= 1'b0;
            out_funtype     <= '0;
            out_funcode     <= '0;
            out_rd          <= '0;
            out_ropa        <= '0;
            out_ropb        <= '0;
            out_ropa_is_reg <= 1'b0;
            out_ropb_is_reg <= 1'b0;
            out_opa         <= '0;
            out_opb         <= '0;
            out_str_data    <= '0;
            out_pc          <= '0;
            out_br_target   <= '0;
            out_wb          <= 1'b0;
            out_memrd       <= 1'b0;
            out_memwr       <= 1'b0;
            out_cachewr     <= 1'b0;
            out_branch      <= 1'b0;
        end else begin
            if (wb_we && (wb_rd != c_zero_reg) && (wb_rd != c_pc_reg))
                r_bank[wb_rd] <= wb_data;

            if (flush) begin
                out_valid <= 1'b0;
                r_ld_pend <= 1'b0;
            end else if (w_advance) begin
                if (w_accept) begin
                    out_valid       <= 1'b1;
                    out_funtype     <= w_funtype;
                    out_funcode     <= w_funcode;
                    out_rd          <= w_rd;
                    out_ropa        <= w_ropa;
                    out_ropb        <= w_ropb;
                    out_ropa_is_reg <= !w_zero_a;
                    out_ropb_is_reg <= !w_use_imm;
                    out_opa         <= w_opa;
                    out_opb         <= w_opb;
                    out_str_data    <= w_val_d;
                    out_pc          <= in_pc;
                    out_br_target   <= in_pc + w_opb;
                    out_wb          <= w_wb;
                    out_memrd       <= w_is_ld;
                    out_memwr       <= w_is_st;
                    out_cachewr     <= w_is_cwr;
                    out_branch      <= w_cls_br;
                    r_ld_pend       <= w_is_ld && (w_rd != c_zero_reg);
                    r_ld_rd         <= w_rd;
                end else begin
                    out_valid <= 1'b0;
                    r_ld_pend <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_decode_stage_pipe
// Brief    : Self-checking bench for decode_stage_pipe: vector table, directed
//            pipeline sequences and a randomized run against a reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_fw_valid, mem_fw_valid;
    logic [3:0]  ex_fw_rd, mem_fw_rd;
    logic [31:0] ex_fw_data, mem_fw_data;
    logic        flush, out_valid, out_ready;
    logic [1:0]  out_funtype, out_funcode;
    logic [3:0]  out_rd, out_ropa, out_ropb;
    logic        out_ropa_is_reg, out_ropb_is_reg;
    logic [31:0] out_opa, out_opb, out_str_data, out_pc, out_br_target;
    logic        out_wb, out_memrd, out_memwr, out_cachewr, out_branch;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_fw_valid(ex_fw_valid), .ex_fw_rd(ex_fw_rd), .ex_fw_data(ex_fw_data),
        .mem_fw_valid(mem_fw_valid), .mem_fw_rd(mem_fw_rd), .mem_fw_data(mem_fw_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_funtype(out_funtype), .out_funcode(out_funcode), .out_rd(out_rd),
        .out_ropa(out_ropa), .out_ropb(out_ropb),
        .out_ropa_is_reg(out_ropa_is_reg), .out_ropb_is_reg(out_ropb_is_reg),
        .out_opa(out_opa), .out_opb(out_opb), .out_str_data(out_str_data),
        .out_pc(out_pc), .out_br_target(out_br_target),
        .out_wb(out_wb), .out_memrd(out_memrd), .out_memwr(out_memwr),
        .out_cachewr(out_cachewr), .out_branch(out_branch)
    );

    typedef struct packed {
        logic [1:0]  funtype, funcode;
        logic [3:0]  rd, ropa, ropb;
        logic        ropa_r, ropb_r;
        logic [31:0] opa, opb, str, pc, tgt;
        logic        wb, memrd, memwr, cachewr, branch;
    } bundle_t;

    typedef struct {
        logic [31:0] instr, opa, opb, str, tgt;
        logic [3:0]  ropa, ropb;
        logic        ropa_r, ropb_r;
        logic [4:0]  flags;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vecs [11];
    logic [31:0] m_bank [16];
    bundle_t     m_out;
    logic        m_valid, m_ldp;
    logic [3:0]  m_ldrd;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_instr = 0; in_pc = 32'h100;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        ex_fw_valid = 0; ex_fw_rd = 0; ex_fw_data = 0;
        mem_fw_valid = 0; mem_fw_rd = 0; mem_fw_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [31:0] d);
        wb_we = 1; wb_rd = r; wb_data = d;
        tick();
        wb_we = 0;
    endtask

    function automatic bundle_t get_act();
        bundle_t a;
        a.funtype = out_funtype; a.funcode = out_funcode; a.rd = out_rd;
        a.ropa = out_ropa; a.ropb = out_ropb;
        a.ropa_r = out_ropa_is_reg; a.ropb_r = out_ropb_is_reg;
        a.opa = out_opa; a.opb = out_opb; a.str = out_str_data;
        a.pc = out_pc; a.tgt = out_br_target;
        a.wb = out_wb; a.memrd = out_memrd; a.memwr = out_memwr;
        a.cachewr = out_cachewr; a.branch = out_branch;
        return a;
    endfunction

    // Architectural register read as seen by the decoder this cycle
    function automatic logic [31:0] mread(input logic [3:0] r, input logic [31:0] pc);
        if (r == 4'd15) return 32'h0;
        if (r == 4'd14) return pc;
        if (ex_fw_valid && ex_fw_rd == r) return ex_fw_data;
        if (mem_fw_valid && mem_fw_rd == r) return mem_fw_data;
        if (wb_we && wb_rd == r) return wb_data;
        return m_bank[r];
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t     b;
        logic [3:0]  op;
        logic [31:0] i19, i28, i4;
        op  = ins[31:28];
        b   = '0;
        b.funtype = ins[31:30]; b.funcode = ins[29:28]; b.rd = ins[27:24]; b.pc = pc;
`ifdef DECODE_IMM_SIGN_EXT_EN
        i19 = {{13{ins[19]}}, ins[19:1]};
        i28 = {{4{ins[27]}}, ins[27:0]};
`else
        i19 = {13'b0, ins[19:1]};
        i28 = {4'b0, ins[27:0]};
`endif
        i4  = {28'b0, ins[23:20]};
        case (op)
            4'h0, 4'h1, 4'h2:         b.wb = 1;
            4'h4:                     begin b.wb = 1; b.memrd = 1; end
            4'h5:                     b.memwr = 1;
            4'h8, 4'h9, 4'hA, 4'hB:   begin b.wb = 1; b.branch = 1; end
            4'hC:                     b.wb = 1;
            4'hE:                     b.cachewr = 1;
            default:                  ;
        endcase
        if (op == 4'h2 || ins[31:30] == 2'b11) begin
            b.ropa = 4'd15; b.ropa_r = 0; b.opa = 0;
        end else begin
            b.ropa   = (op <= 4'h2 || ins[31:30] == 2'b01) ? ins[23:20] : ins[27:24];
            b.ropa_r = 1;
            b.opa    = mread(b.ropa, pc);
        end
        if (ins[0] || b.cachewr) begin
            b.ropb = 4'd15; b.ropb_r = 0;
            b.opb  = b.cachewr ? i4 : ((ins[31:30] == 2'b00) ? i19 : i28);
        end else begin
            b.ropb = ins[19:16]; b.ropb_r = 1; b.opb = mread(b.ropb, pc);
        end
        b.str = mread(b.rd, pc);
        b.tgt = pc + b.opb;
        return b;
    endfunction

    function automatic logic uses_reg(input bundle_t b, input logic [3:0] r);
        return (b.ropa_r && b.ropa == r) || (b.ropb_r && b.ropb == r) || (b.memwr && b.rd == r);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bundle_t     cand;
        logic [31:0] ins, sx_tgt;
        logic        adv, haz, exp_rdy;

        //            instr         opa        opb           str    tgt           ra  rb  ar  br  flags
        vecs[0]  = '{32'h0130000B, 32'h10,  32'h5,        32'h7,  32'h105,     4'd3, 4'd15, 1, 0, 5'b10000};
        vecs[1]  = '{32'h14350000, 32'h10,  32'h22,       32'h0,  32'h122,     4'd3, 4'd5,  1, 1, 5'b10000};
        vecs[2]  = '{32'h31500013, 32'h7,   32'h9,        32'h7,  32'h109,     4'd1, 4'd15, 1, 0, 5'b00000};
        vecs[3]  = '{32'h26300081, 32'h0,   32'h40,       32'h0,  32'h140,     4'd15,4'd15, 0, 0, 5'b10000};
        vecs[4]  = '{32'h42300021, 32'h10,  32'h2300021,  32'h0,  32'h2300121, 4'd3, 4'd15, 1, 0, 5'b11000};
        vecs[5]  = '{32'h55310000, 32'h10,  32'h7,        32'h22, 32'h107,     4'd3, 4'd1,  1, 1, 5'b00100};
        vecs[6]  = '{32'h80000021, 32'h0,   32'h21,       32'h0,  32'h121,     4'd0, 4'd15, 1, 0, 5'b10001};
        vecs[7]  = '{32'hE7A00000, 32'h0,   32'hA,        32'h0,  32'h10A,     4'd15,4'd15, 0, 0, 5'b00010};
        vecs[8]  = '{32'hC0100003, 32'h0,   32'h0100003,  32'h0,  32'h0100103, 4'd15,4'd15, 0, 0, 5'b10000};
        vecs[9]  = '{32'h01E00003, 32'h100, 32'h1,        32'h7,  32'h101,     4'd14,4'd15, 1, 0, 5'b10000};
        vecs[10] = '{32'h11F30000, 32'h0,   32'h10,       32'h7,  32'h110,     4'd15,4'd3,  1, 1, 5'b10000};

        rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_bundle", get_act(), '0);
        rst_n = 1;

        wb_write(4'd3, 32'h10);
        wb_write(4'd5, 32'h22);
        wb_write(4'd1, 32'h7);

        // Decode table: one instruction per cycle, no forwarding
        for (int i = 0; i < 11; i++) begin
            bundle_t a;
            in_valid = 1; in_instr = vecs[i].instr; in_pc = 32'h100;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            tick();
            in_valid = 0;
            a = get_act();
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_hdr", i), {a.funtype, a.funcode, a.rd, a.pc}, {vecs[i].instr[31:24], 32'h100});
            chk($sformatf("vec%0d_opa", i), a.opa, vecs[i].opa);
            chk($sformatf("vec%0d_opb", i), a.opb, vecs[i].opb);
            chk($sformatf("vec%0d_str", i), a.str, vecs[i].str);
            chk($sformatf("vec%0d_tgt", i), a.tgt, vecs[i].tgt);
            chk($sformatf("vec%0d_tags", i), {a.ropa, a.ropb, a.ropa_r, a.ropb_r},
                {vecs[i].ropa, vecs[i].ropb, vecs[i].ropa_r, vecs[i].ropb_r});
            chk($sformatf("vec%0d_flags", i), {a.wb, a.memrd, a.memwr, a.cachewr, a.branch}, vecs[i].flags);
        end

        // Backward branch only reachable with sign extension
        in_valid = 1; in_instr = 32'h8FFFFFF1; in_pc = 32'h100;
        tick();
        in_valid = 0;
`ifdef DECODE_IMM_SIGN_EXT_EN
        sx_tgt = 32'hF1;
`else
        sx_tgt = 32'h100000F1;
`endif
        chk("br_imm28_tgt", out_br_target, sx_tgt);

        // Load-use: LD R2 then ADD R4,R2,R3 -> one bubble, then MEM forwarding
        in_valid = 1; in_instr = 32'h42300021;
        tick();
        in_instr = 32'h04230000;
        #1;
        chk("lu_stall_ready", in_ready, 1'b0);
        tick();
        chk("lu_bubble_valid", out_valid, 1'b0);
        mem_fw_valid = 1; mem_fw_rd = 4'd2; mem_fw_data = 32'hAB;
        #1;
        chk("lu_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 0; mem_fw_valid = 0;
        chk("lu_issue_valid", out_valid, 1'b1);
        chk("lu_issue_opa", out_opa, 32'hAB);
        chk("lu_issue_opb", out_opb, 32'h10);

        // Forwarding priority: EX over WB, then MEM over WB, then WB write-through
        in_valid = 1; in_instr = 32'h0130000B;
        ex_fw_valid = 1; ex_fw_rd = 4'd3; ex_fw_data = 32'h55;
        wb_we = 1; wb_rd = 4'd3; wb_data = 32'h77;
        tick();
        chk("fw_ex_wins", out_opa, 32'h55);
        ex_fw_valid = 0; wb_data = 32'h99;
        tick();
        chk("fw_wb_through", out_opa, 32'h99);
        mem_fw_valid = 1; mem_fw_rd = 4'd3; mem_fw_data = 32'h66; wb_data = 32'h44;
        tick();
        chk("fw_mem_over_wb", out_opa, 32'h66);
        idle();
        tick();

        // Backpressure: bundle held stable while out_ready is low
        in_valid = 1; in_instr = 32'h0130000B;
        tick();
        out_ready = 0; in_instr = 32'h14350000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_ready", c), in_ready, 1'b0);
            tick();
            chk($sformatf("stall%0d_hold", c), {out_valid, out_funcode, out_opa, out_opb},
                {1'b1, 2'b00, 32'h44, 32'h5});
        end
        out_ready = 1;
        #1;
        chk("stall_rel_ready", in_ready, 1'b1);
        tick();
        chk("stall_rel_issue", {out_valid, out_funcode, out_opa, out_opb},
            {1'b1, 2'b01, 32'h44, 32'h22});

        // Flush with a held bundle and a pending input
        out_ready = 0; flush = 1; in_instr = 32'h0130000B;
        #1;
        chk("flush_in_ready", in_ready, 1'b1);
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("flush_valid", out_valid, 1'b0);
        tick();
        chk("flush_dropped", out_valid, 1'b0);

        // Reset mid-stream clears the bundle and the register bank
        in_valid = 1; in_instr = 32'h0130000B;
        tick();
        rst_n = 0;
        #1;
        chk("mrst_in_ready", in_ready, 1'b0);
        tick();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_opa", out_opa, 32'h0);
        rst_n = 1;
        tick();
        in_valid = 0;
        chk("mrst_bank_clear", {out_valid, out_opa}, {1'b1, 32'h0});

        // Randomized run against the reference model
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int r = 0; r < 16; r++) m_bank[r] = 0;
        m_valid = 0; m_ldp = 0; m_ldrd = 0; m_out = '0;
        for (int n = 0; n < 600; n++) begin
            chk($sformatf("rnd%0d_valid", n), out_valid, m_valid);
            if (m_valid) chk($sformatf("rnd%0d_bundle", n), get_act(), m_out);

            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[31:28] = 4'b0100;
            in_valid     = ($urandom_range(0, 3) != 0);
            in_instr     = ins;
            in_pc        = $urandom;
            out_ready    = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            wb_we        = ($urandom_range(0, 2) == 0);
            wb_rd        = 4'($urandom);
            wb_data      = $urandom;
            ex_fw_valid  = ($urandom_range(0, 3) == 0);
            ex_fw_rd     = 4'($urandom);
            ex_fw_data   = $urandom;
            mem_fw_valid = ($urandom_range(0, 3) == 0);
            mem_fw_rd    = 4'($urandom);
            mem_fw_data  = $urandom;
            #1;

            cand    = model_decode(ins, in_pc);
            adv     = !m_valid || out_ready;
            haz     = m_ldp && in_valid && uses_reg(cand, m_ldrd);
            exp_rdy = flush || (adv && !haz);
            chk($sformatf("rnd%0d_in_ready", n), in_ready, exp_rdy);

            if (wb_we && wb_rd < 4'd14) m_bank[wb_rd] = wb_data;
            if (flush) begin
                m_valid = 0; m_ldp = 0;
            end else if (adv) begin
                if (in_valid && exp_rdy) begin
                    m_out   = cand;
                    m_valid = 1;
                    m_ldp   = cand.memrd && cand.rd != 4'd15;
                    m_ldrd  = cand.rd;
                end else begin
                    m_valid = 0; m_ldp = 0;
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
